// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: memory-side stage behind the cpu core.
// Core writes are posted into a small FIFO and complete in one cycle. Reads
// are forwarded from the FIFO when they hit and go to memory when they miss.
// The memory side is a single-outstanding req/ack master that drains posted
// writes in the background.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no memory transaction; choose a read miss or a buffer drain
// RD_REQ  | read miss issued to memory, waiting for mem_ack
// RD_DONE | read data registered; cpu_ready for exactly one cycle
// WR_REQ  | head buffer entry being written to memory, waiting for mem_ack
module cpu_mem_bridge #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_rw,
    input  logic [ADDR_W-1:0]        cpu_address,
    input  logic [DATA_W-1:0]        cpu_datao,
    output logic [DATA_W-1:0]        cpu_data,
    output logic                     cpu_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   wb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_DONE = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [PW-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]       count_q,     count_d;
    logic [DATA_W-1:0]   cpu_data_q,  cpu_data_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]   buf_addr_q [DEPTH];
    logic [ADDR_W-1:0]   buf_addr_d [DEPTH];
    logic [DATA_W-1:0]   buf_data_q [DEPTH];
    logic [DATA_W-1:0]   buf_data_d [DEPTH];

    logic                hit;
    logic [DATA_W-1:0]   hit_data;
    logic                rd_access;
    logic                rd_hit;
    logic                rd_miss;
    logic                wr_accept;
    logic                pop;

    // Forwarding lookup: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) &&
                (buf_addr_q[rd_ptr_q + PW'(k)] == cpu_address)) begin
                hit      = 1'b1;
                hit_data = buf_data_q[rd_ptr_q + PW'(k)];
            end
        end
    end

    // Access decode; full is judged on the registered count so a same-edge pop never frees a slot.
    always_comb begin
        rd_access = cpu_req & cpu_rw & ~reset;
        rd_hit    = rd_access & hit & (state_q != RD_DONE);
        rd_miss   = rd_access & ~hit;
        wr_accept = cpu_req & ~cpu_rw & ~reset & (count_q < CW'(DEPTH));
        pop       = (state_q == WR_REQ) & mem_ack;
    end

    // State register and all datapath flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cpu_data_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cpu_data_q  <= cpu_data_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Buffer storage; validity is tracked by count/pointers, so no reset needed.
    always_ff @(posedge clock) begin
        buf_addr_q <= buf_addr_d;
        buf_data_q <= buf_data_d;
    end

    // Next-state logic, FIFO bookkeeping and transaction capture.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cpu_data_d  = cpu_data_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;

        if (wr_accept) begin
            buf_addr_d[wr_ptr_q] = cpu_address;
            buf_data_d[wr_ptr_q] = cpu_datao;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(wr_accept) - CW'(pop);

        // Forwarded data is latched so cpu_data keeps its last read value afterwards.
        if (rd_hit) begin
            cpu_data_d = hit_data;
        end

        case (state_q)
            IDLE: begin
                if (rd_miss) begin
                    state_d    = RD_REQ;
                    mem_we_d   = 1'b0;
                    mem_addr_d = cpu_address;
                end else if (count_q != '0) begin
                    state_d     = WR_REQ;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = buf_addr_q[rd_ptr_q];
                    mem_wdata_d = buf_data_q[rd_ptr_q];
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    cpu_data_d = mem_rdata;
                    state_d    = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            WR_REQ: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: memory request from state, core handshake from decode.
    always_comb begin
        mem_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
        cpu_ready = ((state_q == RD_DONE) & ~reset) | wr_accept | rd_hit;
        cpu_data  = rd_hit ? hit_data : cpu_data_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        wb_count  = count_q;
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge with scoreboarded memory and read responses.
`timescale 1ns/1ps
module tb_cpu_mem_bridge;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_rw;
    logic [31:0] cpu_address, cpu_datao, cpu_data;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [$clog2(DEPTH):0] wb_count;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_rd[$];
    int          n_pass = 0;
    int          n_total = 0;

    logic        ack_en = 1'b0;
    logic        force_ack = 1'b0;
    int          ack_delay = 0;
    logic [31:0] rd_val = '0;
    int          resp_cnt = 0;
    logic        resp_seen = 1'b0;
    logic        mreq_prev = 1'b0;
    logic [31:0] held_addr = '0;
    logic        held_we = 1'b0;
    mem_txn_t    cur_txn;
    int          w, n;

    cpu_mem_bridge #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_address(cpu_address),
        .cpu_datao(cpu_datao), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_count(wb_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
        exp_mem.push_back({1'b1, a, d});
    endtask

    task automatic exp_read(input logic [31:0] a);
        exp_mem.push_back({1'b0, a, 32'h0});
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, output int waited);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_address = a; cpu_datao = d; waited = 0;
        @(negedge clock);
        while (!cpu_ready && waited < 100) begin
            next_cycle(); waited++; @(negedge clock);
        end
        check("cpu_write_accepted", cpu_ready, 1);
        next_cycle();
        cpu_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [31:0] expd, output int waited);
        exp_rd.push_back(expd);
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_address = a; waited = 0;
        @(negedge clock);
        while (!cpu_ready && waited < 100) begin
            next_cycle(); waited++; @(negedge clock);
        end
        check("cpu_read_completed", cpu_ready, 1);
        next_cycle();
        cpu_req = 1'b0;
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while ((wb_count != 0 || mem_req) && cycles < 100) begin
            next_cycle(); cycles++;
        end
    endtask

    // Memory model: ack ack_delay cycles after mem_req rises, while enabled.
    initial begin
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clock); #1;
            if (mem_req) begin
                resp_cnt  = resp_seen ? resp_cnt + 1 : 0;
                resp_seen = 1'b1;
            end else begin
                resp_cnt  = 0;
                resp_seen = 1'b0;
            end
            mem_ack   = force_ack | (mem_req & ack_en & (resp_cnt >= ack_delay));
            mem_rdata = rd_val;
        end
    end

    // Memory-side monitor: each new request is matched against the expected queue.
    initial begin
        forever begin
            @(negedge clock);
            if (mem_req && !mreq_prev) begin
                held_addr = mem_addr; held_we = mem_we;
                if (exp_mem.size() == 0) begin
                    n_total++;
                    $display("FAIL mem_unexpected: got request we=%0b addr=0x%0h, required none", mem_we, mem_addr);
                end else begin
                    cur_txn = exp_mem.pop_front();
                    check("mem_we", mem_we, cur_txn.we);
                    check("mem_addr", mem_addr, cur_txn.addr);
                    if (cur_txn.we) check("mem_wdata", mem_wdata, cur_txn.wdata);
                end
            end else if (mem_req && mreq_prev) begin
                check("mem_addr_stable", {mem_we, mem_addr}, {held_we, held_addr});
            end
            mreq_prev = mem_req;
        end
    end

    // Core-side monitor: every read completion is matched against the expected data.
    initial begin
        forever begin
            @(negedge clock);
            if (cpu_req && cpu_rw && cpu_ready) begin
                if (exp_rd.size() == 0) begin
                    n_total++;
                    $display("FAIL cpu_unexpected_read: got data 0x%0h, required no completion", cpu_data);
                end else begin
                    check("cpu_data", cpu_data, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_address = '0; cpu_datao = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_data", cpu_data, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_wb_count", wb_count, 0);
        ack_en = 1'b1; ack_delay = 2;
        next_cycle();

        // 1: single posted write and drain
        exp_write(32'h10, 32'hDEADBEEF);
        cpu_write(32'h10, 32'hDEADBEEF, w);
        check("t1_accept_latency", w, 0);
        check("t1_count_after_push", wb_count, 1);
        wait_drain(w);
        check("t1_drain_cycles", w, 4);
        check("t1_count_empty", wb_count, 0);

        // 2: fill buffer, stall on full, wrap pointers
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) exp_write(i, 32'hA0 + i);
        for (int i = 0; i < 4; i++) begin
            cpu_write(i, 32'hA0 + i, w);
            check("t2_accept_latency", w, 0);
        end
        fork
            cpu_write(32'h4, 32'hA4, w);
            begin
                repeat (3) next_cycle();
                @(negedge clock);
                check("t2_full_stall", cpu_ready, 0);
                check("t2_full_count", wb_count, 4);
                ack_en = 1'b1;
            end
        join
        check("t2_accept_after_pop", w, 5);
        wait_drain(w);
        check("t2_drained", wb_count, 0);
        check("t2_all_writes_seen", exp_mem.size(), 0);

        // 3: forwarding of youngest matching entry
        @(negedge clock); ack_en = 1'b0; next_cycle();
        exp_write(32'h20, 32'h1);
        exp_write(32'h20, 32'h2);
        cpu_write(32'h20, 32'h1, w);
        cpu_write(32'h20, 32'h2, w);
        cpu_read(32'h20, 32'h2, w);
        check("t3_hit_latency", w, 0);
        check("t3_count_held", wb_count, 2);
        @(negedge clock); ack_en = 1'b1;
        wait_drain(w);
        check("t3_mem_queue_empty", exp_mem.size(), 0);
        check("t3_rd_queue_empty", exp_rd.size(), 0);

        // 4: read miss with 3-cycle memory latency
        @(negedge clock); ack_delay = 3; rd_val = 32'h12345678; next_cycle();
        exp_read(32'h30);
        cpu_read(32'h30, 32'h12345678, w);
        check("t4_miss_latency", w, 5);
        @(negedge clock);
        check("t4_ready_one_cycle", cpu_ready, 0);
        check("t4_data_holds", cpu_data, 32'h12345678);
        next_cycle();

        // 5: read miss waits behind an in-flight drain
        @(negedge clock); ack_delay = 4; rd_val = 32'h5555AAAA; next_cycle();
        exp_write(32'h40, 32'h4040);
        exp_read(32'h50);
        cpu_write(32'h40, 32'h4040, w);
        next_cycle();
        fork
            cpu_read(32'h50, 32'h5555AAAA, w);
            begin
                repeat (4) next_cycle();
                @(negedge clock);
                check("t5_write_acked_cycle", {mem_req, mem_we, mem_ack}, 3'b111);
                next_cycle(); @(negedge clock);
                check("t5_gap_cycle", mem_req, 0);
                next_cycle(); @(negedge clock);
                check("t5_read_issued", {mem_req, mem_we}, 2'b10);
            end
        join
        check("t5_read_latency", w, 11);

        // 6: reset in RD_REQ with buffered writes
        @(negedge clock); ack_en = 1'b0; ack_delay = 1; next_cycle();
        exp_write(32'h60, 32'h6060);
        exp_read(32'h70);
        cpu_write(32'h60, 32'h6060, w);
        cpu_write(32'h61, 32'h6161, w);
        cpu_write(32'h62, 32'h6262, w);
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_address = 32'h70;
        @(negedge clock);
        check("t6_miss_stalled", cpu_ready, 0);
        ack_en = 1'b1;
        n = 0;
        while (!(mem_req && !mem_we) && n < 20) begin
            @(negedge clock); n++;
        end
        ack_en = 1'b0;
        check("t6_in_rd_req", {mem_req, mem_we}, 2'b10);
        check("t6_count_before_reset", wb_count, 2);
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clock);
        check("t6_rst_mem_req", mem_req, 0);
        check("t6_rst_cpu_ready", cpu_ready, 0);
        check("t6_rst_count", wb_count, 0);
        reset = 1'b0; force_ack = 1'b1;
        repeat (2) @(negedge clock);
        check("t6_stray_ack_mem_req", mem_req, 0);
        check("t6_stray_ack_count", wb_count, 0);
        force_ack = 1'b0; ack_en = 1'b1; ack_delay = 0; rd_val = 32'hCAFEF00D;
        next_cycle();
        exp_read(32'h60);
        cpu_read(32'h60, 32'hCAFEF00D, w);
        check("t6_min_miss_latency", w, 2);
        check("t6_mem_queue_empty", exp_mem.size(), 0);
        check("t6_rd_queue_empty", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Memory-side stage directly downstream of the cpu core; consumes the core's address, write data and rw strobe, and returns read data.
- Contains a DEPTH-entry posted write buffer (FIFO), read forwarding from that buffer, and a single-outstanding req/ack master toward a wait-state memory.
- Lets core writes complete in one cycle while memory drains them in the background.

Parameters:
DEPTH, 4, write-buffer entries; power of two, at least 2
ADDR_W, 32, address width (word addresses)
DATA_W, 32, data width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  core access valid this cycle
cpu_rw  in  1  1 = read, 0 = write (core convention)
cpu_address  in  ADDR_W  access address
cpu_datao  in  DATA_W  write data
cpu_data  out  DATA_W  read data, valid when cpu_ready & cpu_rw
cpu_ready  out  1  access completes this cycle
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write transaction
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  transaction write data
mem_rdata  in  DATA_W  read data, sampled on mem_ack
mem_ack  in  1  transaction done; ignored unless mem_req = 1
wb_count  out  $clog2(DEPTH)+1  current buffer occupancy

Behaviour:
- Reset (synchronous, active-high): wb_count, read/write pointers = 0; FSM = IDLE.
- Reset drives the following outputs to 0: mem_req, mem_we, mem_addr, mem_wdata, cpu_data, cpu_ready.
- Reset mid-transaction abandons it: mem_req is 0 the cycle after reset is sampled, and buffered writes are discarded.
- Core contract: while cpu_req = 1 and cpu_ready = 0, the core holds address, rw and datao stable. At most one request is outstanding.
- Write accept: cpu_req & ~cpu_rw & (wb_count < DEPTH) gives cpu_ready = 1 combinationally in the same cycle. The entry {address, data} is pushed at that edge.
- Full uses the registered wb_count. A pop on the same edge does not allow a push; the write is accepted the following cycle.
- Read hit: cpu_req & cpu_rw, and cpu_address equals any valid entry (full-width compare).
  - cpu_ready = 1 in the same cycle; cpu_data = data of the youngest matching entry (combinational); no memory read.
  - The entry currently being drained still counts as valid until popped.
- Read miss (no match): FSM states IDLE, RD_REQ, RD_DONE, WR_REQ.
  - IDLE, read miss -> RD_REQ. mem_req = 1, mem_we = 0, mem_addr = cpu_address, all held stable until mem_ack.
  - On mem_ack: cpu_data <= mem_rdata; -> RD_DONE.
  - RD_DONE: cpu_ready = 1 for exactly one cycle, cpu_data holds the registered value; -> IDLE.
  - Minimum read-miss latency: request in cycle 0, ack in cycle 1, ready in cycle 2.
- Drain:
  - IDLE with wb_count > 0 and no read miss pending -> WR_REQ. mem_req = 1, mem_we = 1, addr/wdata = head entry, held stable until mem_ack.
  - On mem_ack: pop head, wb_count - 1; -> IDLE.
  - mem_req is low for at least one cycle between transactions (passes through IDLE).
- Priority: in IDLE, a read miss beats starting a drain. A started WR_REQ is never aborted; a read miss arriving meanwhile waits (cpu_ready = 0) until it completes.
- Simultaneous push and pop: wb_count unchanged; pointers advance modulo DEPTH.
- Wrap-around: pointers are $clog2(DEPTH) bits wide, and FIFO order is preserved across wrap.
- Ordering: memory sees writes in program order. A read to an address not in the buffer may complete before older buffered writes drain; forwarding keeps this coherent.
- cpu_data outside read completion holds its last value. cpu_ready = 0 when cpu_req = 0, except in RD_DONE.
- mem_ack while mem_req = 0 is ignored.

Test Plan:
1. Reset, then write 0x10 = 0xDEADBEEF.
   - Required: cpu_ready = 1 same cycle; wb_count = 1 next cycle.
   - Required: mem_req/mem_we rise with mem_addr = 0x10 and mem_wdata = 0xDEADBEEF; after ack 2 cycles later, wb_count = 0.
2. mem_ack held 0; four writes 0x0..0x3 accepted back-to-back; fifth write 0x4.
   - Required: cpu_ready = 0 and wb_count = 4 until the first ack, then accepted one cycle after the pop.
   - Required: memory sees addresses 0..4 in order across pointer wrap.
3. With ack held 0, buffer writes 0x20 = 1 then 0x20 = 2; read 0x20.
   - Required: cpu_ready same cycle, cpu_data = 2, no mem_we = 0 request issued.
4. Empty buffer; read 0x30; memory returns 0x12345678 with ack 3 cycles after mem_req rises.
   - Required: cpu_ready = 1 exactly one cycle, the cycle after ack, with cpu_data = 0x12345678.
5. Drain of 0x40 in flight (ack delayed 4 cycles); read miss 0x50 arrives.
   - Required: write to 0x40 completes first, mem_req drops one cycle, then read of 0x50 is issued.
6. Reset asserted while in RD_REQ with 2 entries buffered.
   - Required: next cycle mem_req = 0, cpu_ready = 0, wb_count = 0, FSM IDLE; a later mem_ack is ignored.
